// File: rtl/axi_txn_scheduler.sv
// Round-robin, transaction-level arbiter sharing one AXI slave among NUM_M masters.
// One full AW->B or AR->R(last) transaction per grant, with a stall watchdog.
module axi_txn_scheduler #(
  parameter int NUM_M  = 2,
  parameter int TO_CYC = 1024,
  localparam int IDX_W = $clog2(NUM_M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_M-1:0] m_awvalid,
  input  logic [NUM_M-1:0] m_arvalid,
  input  logic             s_awready,
  input  logic             s_arready,
  input  logic             s_bvalid,
  input  logic             s_bready,
  input  logic             s_rvalid,
  input  logic             s_rready,
  input  logic             s_rlast,
  output logic [NUM_M-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy,
  output logic             txn_is_write,
  output logic             timeout_err
);

  localparam int WD_W = $clog2(TO_CYC);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_t;

  state_t state, state_n;

  logic [NUM_M-1:0] req;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] idx_n;
  logic [NUM_M-1:0] gnt_n;
  logic [WD_W-1:0]  wd, wd_n;
  logic             wr_n;
  logic             to_n;
  logic             busy_n;
  logic             hs;
  logic             done;
  logic             expire;
  int               j;

  assign req = m_awvalid | m_arvalid;

  // Search from the pointer; iterating downwards leaves the nearest requester.
  always_comb begin
    win  = '0;
    cand = '0;
    j    = 0;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_M) j = j - NUM_M;
      cand = IDX_W'(j);
      if (req[cand]) win = cand;
    end
  end

  always_comb begin
    hs   = 1'b0;
    done = 1'b0;
    unique case (state)
      WR_ADDR: hs = m_awvalid[gnt_idx] & s_awready;
      WR_RESP: begin
        hs   = s_bvalid & s_bready;
        done = hs;
      end
      RD_ADDR: hs = m_arvalid[gnt_idx] & s_arready;
      RD_DATA: begin
        hs   = s_rvalid & s_rready;
        done = hs & s_rlast;
      end
      default: ;
    endcase
  end

  assign expire = (state != IDLE) & ~hs &
                  (wd == WD_W'(TO_CYC - 1));

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    idx_n   = gnt_idx;
    wr_n    = txn_is_write;
    ptr_n   = ptr;
    wd_n    = wd;
    to_n    = 1'b0;
    if (state == IDLE) begin
      wd_n = '0;
      if (|req) begin
        idx_n        = win;
        gnt_n        = '0;
        gnt_n[win]   = 1'b1;
        wr_n         = m_awvalid[win];
        state_n      = m_awvalid[win] ? WR_ADDR : RD_ADDR;
      end
    end else if (done || expire) begin
      state_n = IDLE;
      gnt_n   = '0;
      wd_n    = '0;
      to_n    = expire;
      if (gnt_idx == IDX_W'(NUM_M - 1)) ptr_n = '0;
      else ptr_n = gnt_idx + IDX_W'(1);
    end else if (hs) begin
      wd_n = '0;
      if (state == WR_ADDR) state_n = WR_RESP;
      if (state == RD_ADDR) state_n = RD_DATA;
    end else begin
      wd_n = wd + WD_W'(1);
    end
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= '0;
      wd           <= '0;
      gnt          <= '0;
      gnt_idx      <= '0;
      busy         <= 1'b0;
      txn_is_write <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      wd           <= wd_n;
      gnt          <= gnt_n;
      gnt_idx      <= idx_n;
      busy         <= busy_n;
      txn_is_write <= wr_n;
      timeout_err  <= to_n;
    end
  end

endmodule

// File: tb/tb_axi_txn_scheduler.sv
// Directed bench for axi_txn_scheduler (NUM_M=2, TO_CYC=16).
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_axi_txn_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] m_awvalid;
  logic [1:0] m_arvalid;
  logic       s_awready;
  logic       s_arready;
  logic       s_bvalid;
  logic       s_bready;
  logic       s_rvalid;
  logic       s_rready;
  logic       s_rlast;
  logic [1:0] gnt;
  logic [0:0] gnt_idx;
  logic       busy;
  logic       txn_is_write;
  logic       timeout_err;

  int checks = 0;
  int failures = 0;

  logic [1:0] seq2 [8];
  logic [2:0] beats [7];

  always #5 clk = ~clk;

  axi_txn_scheduler #(
    .NUM_M (2),
    .TO_CYC(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_awvalid   (m_awvalid),
    .m_arvalid   (m_arvalid),
    .s_awready   (s_awready),
    .s_arready   (s_arready),
    .s_bvalid    (s_bvalid),
    .s_bready    (s_bready),
    .s_rvalid    (s_rvalid),
    .s_rready    (s_rready),
    .s_rlast     (s_rlast),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx),
    .busy        (busy),
    .txn_is_write(txn_is_write),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    m_awvalid = '0;
    m_arvalid = '0;
    s_awready = 0;
    s_arready = 0;
    s_bvalid  = 0;
    s_bready  = 0;
    s_rvalid  = 0;
    s_rready  = 0;
    s_rlast   = 0;
  endtask

  initial begin
    seq2  = '{2'b10, 2'b00, 2'b01, 2'b01,
              2'b00, 2'b10, 2'b10, 2'b00};
    beats = '{3'b110, 3'b100, 3'b110, 3'b010,
              3'b110, 3'b101, 3'b111};
    rst = 0;
    clr();
    tick();
    tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_idx", gnt_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr", txn_is_write, 0);
    chk("rst_to", timeout_err, 0);
    rst = 1;
    tick();

    // write from master0: AW at c3, B at c5
    m_awvalid = 2'b01;
    tick();
    chk("t1_gnt", gnt, 1);
    chk("t1_busy", busy, 1);
    chk("t1_wr", txn_is_write, 1);
    chk("t1_idx", gnt_idx, 0);
    tick();
    s_awready = 1;
    tick();
    chk("t1_aw_gnt", gnt, 1);
    s_awready = 0;
    m_awvalid = 0;
    tick();
    s_bvalid = 1;
    s_bready = 1;
    tick();
    chk("t1_rel_gnt", gnt, 0);
    chk("t1_rel_busy", busy, 0);
    clr();
    m_arvalid = 2'b11;
    tick();
    chk("t1_ptr_gnt", gnt, 2);
    chk("t1_ptr_idx", gnt_idx, 1);
    chk("t1_ptr_wr", txn_is_write, 0);

    // single-beat reads, both masters: strict alternation
    s_arready = 1;
    s_rvalid  = 1;
    s_rready  = 1;
    s_rlast   = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("t2_seq%0d", i), gnt, seq2[i]);
    end
    clr();
    tick();

    // master0 write+read, master1 read
    m_awvalid = 2'b01;
    m_arvalid = 2'b11;
    tick();
    chk("t3_gnt", gnt, 1);
    chk("t3_wr", txn_is_write, 1);
    s_awready = 1;
    tick();
    s_awready = 0;
    m_awvalid = 0;
    s_bvalid  = 1;
    s_bready  = 1;
    tick();
    chk("t3_rel", gnt, 0);
    s_bvalid = 0;
    s_bready = 0;
    tick();
    chk("t3_m1_gnt", gnt, 2);
    chk("t3_m1_wr", txn_is_write, 0);
    s_arready = 1;
    tick();
    s_arready = 0;
    m_arvalid = 2'b01;
    s_rvalid  = 1;
    s_rready  = 1;
    s_rlast   = 1;
    tick();
    chk("t3_m1_rel", gnt, 0);
    s_rvalid = 0;
    s_rready = 0;
    s_rlast  = 0;
    tick();
    chk("t3_m0rd_gnt", gnt, 1);
    chk("t3_m0rd_wr", txn_is_write, 0);

    // 4-beat read with gaps
    s_arready = 1;
    tick();
    s_arready = 0;
    m_arvalid = 0;
    for (int i = 0; i < 7; i++) begin
      {s_rvalid, s_rready, s_rlast} = beats[i];
      tick();
      chk($sformatf("t4_beat%0d", i), gnt,
          (i == 6) ? 0 : 1);
    end
    clr();

    // watchdog in WR_RESP, master1
    m_awvalid = 2'b10;
    tick();
    chk("t5_gnt", gnt, 2);
    s_awready = 1;
    tick();
    s_awready = 0;
    m_awvalid = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("t5_hold%0d", i), gnt, 2);
      chk($sformatf("t5_to%0d", i), timeout_err, 0);
    end
    m_arvalid = 2'b01;
    tick();
    chk("t5_exp_gnt", gnt, 0);
    chk("t5_exp_to", timeout_err, 1);
    chk("t5_exp_busy", busy, 0);
    tick();
    chk("t5_after_to", timeout_err, 0);
    chk("t5_regnt", gnt, 1);

    // AR handshake exactly at expiry count
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("t5_ar%0d", i), timeout_err, 0);
    end
    s_arready = 1;
    tick();
    chk("t5_arhs_gnt", gnt, 1);
    chk("t5_arhs_to", timeout_err, 0);
    s_arready = 0;
    m_arvalid = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("t5_rd%0d", i), gnt, 1);
    end
    s_rvalid = 1;
    s_rready = 1;
    s_rlast  = 1;
    tick();
    chk("t5_simul_gnt", gnt, 0);
    chk("t5_simul_to", timeout_err, 0);
    clr();

    // async reset mid RD_DATA
    m_arvalid = 2'b10;
    tick();
    chk("t6_gnt", gnt, 2);
    s_arready = 1;
    tick();
    s_arready = 0;
    m_arvalid = 0;
    s_rvalid  = 1;
    #2;
    rst = 0;
    #1;
    chk("t6_async_gnt", gnt, 0);
    chk("t6_async_busy", busy, 0);
    s_rvalid  = 0;
    m_arvalid = 2'b11;
    tick();
    chk("t6_held_gnt", gnt, 0);
    rst = 1;
    tick();
    chk("t6_post_gnt", gnt, 1);
    chk("t6_post_idx", gnt_idx, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
